fetch_stage: RTL and testbench
==============================

FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter RESET_PC, default 12'h000: PC value loaded on reset.
REQ-002 Parameter HALT_OPCODE, default 4'hF: instruction[15:12] value that halts fetch.
REQ-003 Port clk  input  1: single clock; all state updates on rising edge.
REQ-004 Port reset_n  input  1: asynchronous, active-low reset.
REQ-005 Port stall  input  1: hazard-unit hold request (load-use); freezes PC and IF/ID.
REQ-006 Port br_taken  input  1: redirect request from execute stage.
REQ-007 Port br_target  input  12: redirect PC, valid when br_taken=1.
REQ-008 Port M_instruction  input  16: combinational instruction-memory read data for PCAdd_pc.
REQ-009 Port PCAdd_pc  output  12: current PC, drives instruction-memory address.
REQ-010 Port IF_ID_instruction  output  16: registered instruction to decode.
REQ-011 Port IF_ID_pc  output  12: registered PC of IF_ID_instruction.
REQ-012 Port IF_ID_valid  output  1: IF/ID slot holds a real instruction.
REQ-013 Port halted  output  1: fetch is in HALT state.
REQ-014 Port fetch_count  output  16: retired-fetch counter (see Configuration).

Function
REQ-015 FSM states BOOT, RUN, HALT; BOOT lasts exactly one cycle after reset release, then RUN.
REQ-016 BOOT: PC held, IF_ID_valid=0; the first instruction (at RESET_PC) appears in IF/ID with valid=1 at the end of the first RUN cycle.
REQ-017 RUN, no stall/branch: IF/ID <= {M_instruction, PCAdd_pc, 1}; PC <= PC+1 each cycle (latency one cycle, PC to IF/ID).
REQ-018 PC increment is 12-bit modular; 12'hFFF + 1 wraps to 12'h000 with no flag.
REQ-019 Priority per cycle: reset > br_taken > stall > normal advance.
REQ-020 br_taken=1 (any state): PC <= br_target, IF_ID_valid <= 0 (flush), state <= RUN; stall ignored that cycle.
REQ-021 stall=1, br_taken=0: PC, IF_ID_instruction, IF_ID_pc, IF_ID_valid all hold their values.
REQ-022 RUN, M_instruction[15:12]==HALT_OPCODE, no stall/branch: halt instruction is latched into IF/ID with valid=1, PC holds, state <= HALT.
REQ-023 HALT: PC holds, IF_ID_valid <= 0 from the next cycle, halted=1; exit only via br_taken or reset.
REQ-024 Halt opcode fetched under stall is not acted upon until stall deasserts.
REQ-025 halted=1 exactly when state==HALT; combinational from state register.

Reset
REQ-026 reset_n=0 immediately (asynchronously) forces PC=RESET_PC, state=BOOT, IF_ID_instruction=16'h0000, IF_ID_pc=12'h000, IF_ID_valid=0, fetch_count=0, halted=0.
REQ-027 Reset asserted mid-stall, mid-branch or in HALT discards all in-flight state; no partial update survives.
REQ-028 Reset release is sampled synchronously; the first state change occurs on the first rising edge with reset_n=1.

Configuration
REQ-029 Macro FETCH_PERF_CNT_EN defined: fetch_count increments by 1 (16-bit wrap) on every edge where IF_ID_valid is written 1 with new data (not on hold, flush or BOOT).
REQ-030 FETCH_PERF_CNT_EN undefined: no counter register is built; fetch_count is constant 16'h0000.

Verification
REQ-031 Reset release, memory {0:16'h6141, 1:16'h6242, 2:16'h6313} -> cycle1 valid=0; cycle2 IF_ID={16'h6141,pc 0}; cycle3 {16'h6242,pc 1}; cycle4 {16'h6313,pc 2}.
REQ-032 stall=1 for 2 cycles while IF_ID holds pc 1 -> IF_ID and PCAdd_pc (2) unchanged 2 cycles; resumes with pc 2 next.
REQ-033 br_taken=1, br_target=12'h00A, stall=1 same cycle -> next cycle PCAdd_pc=12'h00A, IF_ID_valid=0; following cycle IF_ID_pc=12'h00A.
REQ-034 Memory word 16'hF000 at address 5 -> IF_ID holds it with valid=1, halted=1, PCAdd_pc stays 5, valid=0 after; br_taken to 12'h000 restarts fetch.
REQ-035 PC forced to 12'hFFF via br_target -> next fetch PCAdd_pc=12'h000.
REQ-036 With FETCH_PERF_CNT_EN: 4 valid fetches, 2 stall cycles, 1 flush -> fetch_count=4; without macro -> 0; reset_n pulsed low mid-sequence -> all outputs at reset values before next edge.

Source files
------------

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC register, IF/ID pipeline latch and BOOT/RUN/HALT control.
// Optional retired-fetch counter is built only when FETCH_PERF_CNT_EN is defined.
module fetch_stage #(
    parameter logic [11:0] RESET_PC    = 12'h000,
    parameter logic [3:0]  HALT_OPCODE = 4'hF
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        stall,
    input  logic        br_taken,
    input  logic [11:0] br_target,
    input  logic [15:0] M_instruction,
    output logic [11:0] PCAdd_pc,
    output logic [15:0] IF_ID_instruction,
    output logic [11:0] IF_ID_pc,
    output logic        IF_ID_valid,
    output logic        halted,
    output logic [15:0] fetch_count
);

    typedef enum logic [1:0] {
        StBoot = 2'd0,
        StRun  = 2'd1,
        StHalt = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic [11:0] pc_q, pc_d;
    logic [15:0] ifid_instr_q, ifid_instr_d;
    logic [11:0] ifid_pc_q, ifid_pc_d;
    logic        ifid_valid_q, ifid_valid_d;
    logic        is_halt_op;

    assign is_halt_op = (M_instruction[15:12] == HALT_OPCODE);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= StBoot;
            pc_q         <= RESET_PC;
            ifid_instr_q <= 16'h0000;
            ifid_pc_q    <= 12'h000;
            ifid_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            ifid_instr_q <= ifid_instr_d;
            ifid_pc_q    <= ifid_pc_d;
            ifid_valid_q <= ifid_valid_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        ifid_instr_d = ifid_instr_q;
        ifid_pc_d    = ifid_pc_q;
        ifid_valid_d = ifid_valid_q;

        if (br_taken) begin
            // Redirect wins over stall; the slot is flushed but its payload left as is.
            state_d      = StRun;
            pc_d         = br_target;
            ifid_valid_d = 1'b0;
        end else if (!stall) begin
            unique case (state_q)
                StBoot: begin
                    state_d      = StRun;
                    ifid_valid_d = 1'b0;
                end
                StRun: begin
                    ifid_instr_d = M_instruction;
                    ifid_pc_d    = pc_q;
                    ifid_valid_d = 1'b1;
                    if (is_halt_op) begin
                        state_d = StHalt;
                    end else begin
                        pc_d = pc_q + 12'd1;
                    end
                end
                StHalt: begin
                    ifid_valid_d = 1'b0;
                end
                default: begin
                    state_d      = StBoot;
                    ifid_valid_d = 1'b0;
                end
            endcase
        end
    end

    assign PCAdd_pc          = pc_q;
    assign IF_ID_instruction = ifid_instr_q;
    assign IF_ID_pc          = ifid_pc_q;
    assign IF_ID_valid       = ifid_valid_q;
    assign halted            = (state_q == StHalt);

`ifdef FETCH_PERF_CNT_EN
    logic [15:0] cnt_q, cnt_d;
    logic        cnt_inc;

    // Every unstalled, unredirected RUN cycle writes a fresh valid instruction.
    assign cnt_inc = !br_taken && !stall && (state_q == StRun);
    assign cnt_d   = cnt_inc ? cnt_q + 16'd1 : cnt_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= 16'h0000;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign fetch_count = cnt_q;
`else
    assign fetch_count = 16'h0000;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed vector bench for fetch_stage with a small instruction memory model.
module tb_fetch_stage;

    logic        clk;
    logic        reset_n;
    logic        stall;
    logic        br_taken;
    logic [11:0] br_target;
    logic [15:0] M_instruction;
    logic [11:0] PCAdd_pc;
    logic [15:0] IF_ID_instruction;
    logic [11:0] IF_ID_pc;
    logic        IF_ID_valid;
    logic        halted;
    logic [15:0] fetch_count;

    logic [15:0] mem [4096];

    int n_total = 0;
    int n_pass  = 0;

    fetch_stage #(
        .RESET_PC   (12'h000),
        .HALT_OPCODE(4'hF)
    ) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .stall            (stall),
        .br_taken         (br_taken),
        .br_target        (br_target),
        .M_instruction    (M_instruction),
        .PCAdd_pc         (PCAdd_pc),
        .IF_ID_instruction(IF_ID_instruction),
        .IF_ID_pc         (IF_ID_pc),
        .IF_ID_valid      (IF_ID_valid),
        .halted           (halted),
        .fetch_count      (fetch_count)
    );

    assign M_instruction = mem[PCAdd_pc];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        stall;
        logic        br;
        logic [11:0] tgt;
        logic [11:0] pc;
        logic [15:0] instr;
        logic [11:0] ipc;
        logic        valid;
        logic        halt;
        logic [15:0] cnt;
    } vec_t;

    localparam int NVEC = 22;
    vec_t vecs [NVEC];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] cnt_exp(input logic [15:0] c);
`ifdef FETCH_PERF_CNT_EN
        return c;
`else
        return 16'h0000;
`endif
    endfunction

    task automatic check_reset_vals(input string tag);
        check({tag, " pc"},    32'(PCAdd_pc),          32'h000);
        check({tag, " instr"}, 32'(IF_ID_instruction), 32'h0000);
        check({tag, " ipc"},   32'(IF_ID_pc),          32'h000);
        check({tag, " valid"}, 32'(IF_ID_valid),       32'h0);
        check({tag, " halt"},  32'(halted),            32'h0);
        check({tag, " cnt"},   32'(fetch_count),       32'h0);
    endtask

    initial begin
        foreach (mem[i]) mem[i] = 16'h0000;
        mem[12'h000] = 16'h6141;
        mem[12'h001] = 16'h6242;
        mem[12'h002] = 16'h6313;
        mem[12'h003] = 16'h6404;
        mem[12'h004] = 16'h6505;
        mem[12'h005] = 16'hF000;
        mem[12'h00A] = 16'h610A;
        mem[12'h00B] = 16'h620B;
        mem[12'hFFF] = 16'h6FFF;

        //            stall br  tgt      pc       instr     ipc      v     h     cnt
        vecs[0]  = '{1'b0, 1'b0, 12'h000, 12'h000, 16'h0000, 12'h000, 1'b0, 1'b0, 16'd0};
        vecs[1]  = '{1'b0, 1'b0, 12'h000, 12'h001, 16'h6141, 12'h000, 1'b1, 1'b0, 16'd1};
        vecs[2]  = '{1'b0, 1'b0, 12'h000, 12'h002, 16'h6242, 12'h001, 1'b1, 1'b0, 16'd2};
        vecs[3]  = '{1'b1, 1'b0, 12'h000, 12'h002, 16'h6242, 12'h001, 1'b1, 1'b0, 16'd2};
        vecs[4]  = '{1'b1, 1'b0, 12'h000, 12'h002, 16'h6242, 12'h001, 1'b1, 1'b0, 16'd2};
        vecs[5]  = '{1'b0, 1'b0, 12'h000, 12'h003, 16'h6313, 12'h002, 1'b1, 1'b0, 16'd3};
        vecs[6]  = '{1'b1, 1'b1, 12'h00A, 12'h00A, 16'h6313, 12'h002, 1'b0, 1'b0, 16'd3};
        vecs[7]  = '{1'b0, 1'b0, 12'h000, 12'h00B, 16'h610A, 12'h00A, 1'b1, 1'b0, 16'd4};
        vecs[8]  = '{1'b0, 1'b1, 12'h005, 12'h005, 16'h610A, 12'h00A, 1'b0, 1'b0, 16'd4};
        vecs[9]  = '{1'b0, 1'b0, 12'h000, 12'h005, 16'hF000, 12'h005, 1'b1, 1'b1, 16'd5};
        vecs[10] = '{1'b0, 1'b0, 12'h000, 12'h005, 16'hF000, 12'h005, 1'b0, 1'b1, 16'd5};
        vecs[11] = '{1'b0, 1'b0, 12'h000, 12'h005, 16'hF000, 12'h005, 1'b0, 1'b1, 16'd5};
        vecs[12] = '{1'b0, 1'b1, 12'h000, 12'h000, 16'hF000, 12'h005, 1'b0, 1'b0, 16'd5};
        vecs[13] = '{1'b0, 1'b0, 12'h000, 12'h001, 16'h6141, 12'h000, 1'b1, 1'b0, 16'd6};
        vecs[14] = '{1'b0, 1'b1, 12'hFFF, 12'hFFF, 16'h6141, 12'h000, 1'b0, 1'b0, 16'd6};
        vecs[15] = '{1'b0, 1'b0, 12'h000, 12'h000, 16'h6FFF, 12'hFFF, 1'b1, 1'b0, 16'd7};
        vecs[16] = '{1'b0, 1'b0, 12'h000, 12'h001, 16'h6141, 12'h000, 1'b1, 1'b0, 16'd8};
        vecs[17] = '{1'b0, 1'b1, 12'h005, 12'h005, 16'h6141, 12'h000, 1'b0, 1'b0, 16'd8};
        vecs[18] = '{1'b1, 1'b0, 12'h000, 12'h005, 16'h6141, 12'h000, 1'b0, 1'b0, 16'd8};
        vecs[19] = '{1'b0, 1'b0, 12'h000, 12'h005, 16'hF000, 12'h005, 1'b1, 1'b1, 16'd9};
        vecs[20] = '{1'b0, 1'b1, 12'h002, 12'h002, 16'hF000, 12'h005, 1'b0, 1'b0, 16'd9};
        vecs[21] = '{1'b0, 1'b0, 12'h000, 12'h003, 16'h6313, 12'h002, 1'b1, 1'b0, 16'd10};

        reset_n   = 1'b0;
        stall     = 1'b0;
        br_taken  = 1'b0;
        br_target = 12'h000;
        repeat (2) @(posedge clk);
        #1;
        check_reset_vals("reset");

        // Release between edges; each vector then covers exactly one rising edge.
        reset_n = 1'b1;
        for (int i = 0; i < NVEC; i++) begin
            stall     = vecs[i].stall;
            br_taken  = vecs[i].br;
            br_target = vecs[i].tgt;
            @(posedge clk);
            #1;
            check($sformatf("v%0d pc", i),    32'(PCAdd_pc),          32'(vecs[i].pc));
            check($sformatf("v%0d instr", i), 32'(IF_ID_instruction), 32'(vecs[i].instr));
            check($sformatf("v%0d ipc", i),   32'(IF_ID_pc),          32'(vecs[i].ipc));
            check($sformatf("v%0d valid", i), 32'(IF_ID_valid),       32'(vecs[i].valid));
            check($sformatf("v%0d halt", i),  32'(halted),            32'(vecs[i].halt));
            check($sformatf("v%0d cnt", i),   32'(fetch_count),       32'(cnt_exp(vecs[i].cnt)));
        end

        // Asynchronous reset in the middle of a stalled redirect.
        stall     = 1'b1;
        br_taken  = 1'b1;
        br_target = 12'h007;
        #2;
        reset_n = 1'b0;
        #1;
        check_reset_vals("async");
        @(posedge clk);
        #1;
        check_reset_vals("held");

        stall    = 1'b0;
        br_taken = 1'b0;
        reset_n  = 1'b1;
        @(posedge clk);
        #1;
        check("boot pc",    32'(PCAdd_pc),    32'h000);
        check("boot valid", 32'(IF_ID_valid), 32'h0);
        @(posedge clk);
        #1;
        check("first instr", 32'(IF_ID_instruction), 32'h6141);
        check("first valid", 32'(IF_ID_valid),       32'h1);
        check("first pc",    32'(PCAdd_pc),          32'h001);
        check("first cnt",   32'(fetch_count),       32'(cnt_exp(16'd1)));

        // Reset while halted.
        br_taken  = 1'b1;
        br_target = 12'h005;
        @(posedge clk);
        #1;
        br_taken = 1'b0;
        @(posedge clk);
        #1;
        check("pre halt", 32'(halted), 32'h1);
        #2;
        reset_n = 1'b0;
        #1;
        check_reset_vals("halt rst");
        #1;
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        check("post rst halt", 32'(halted), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
